ex_div_seq: RTL and testbench
=============================

# ex_div_seq

Multi-cycle 32-bit integer divide sequencer for the execute stage. It accepts signed or unsigned DIV/DIVU operands from the EX stage and runs a radix-2 restoring divide, one quotient bit per clock. It reports completion with a ready/hold handshake. While it is busy, EX holds its stall request, and the pipeline controller stalls the earlier stages.

## Interface
Parameters:
- DATA_W, 32, operand width; the result is 2*DATA_W.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0); one clock domain only.
- start_i  in  1  divide request from EX; held high until ready_o is observed.
- annul_i  in  1  flush or cancel from the pipeline controller.
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- result_o  out  2*DATA_W  {remainder, quotient}; the HI half is the remainder, the LO half is the quotient.
- ready_o  out  1  result valid.
- busy_o  out  1  high in BY_ZERO and ON.

## Operation
States are FREE, BY_ZERO, ON and END.

FREE:
- If start_i=1 and annul_i=0, capture the operands and signed_div_i.
- If the divisor is 0, go to BY_ZERO.
- Otherwise go to ON, with cnt=0 and the partial remainder cleared.
- For signed divides, replace negative operands by their two's-complement magnitude at capture.
- Operand changes after capture are ignored.

BY_ZERO:
- Next edge goes to END with result = 0.

ON, one restoring step per edge while cnt<32:
- Shift {rem, dividend} left by 1.
- Trial = rem − divisor, computed DATA_W+1 bits wide.
- If the trial is non-negative: rem = trial and quotient bit = 1. Otherwise rem is unchanged and the quotient bit = 0.
- cnt increments.
- At cnt==32 the next edge applies the sign fix-up, registers result_o and goes to END.
- Sign fix-up (signed only): negate the quotient when the operand signs differ; negate the remainder when the dividend was negative.
- −2^31 / −1 yields quotient 0x80000000, remainder 0 (wraps, no trap).

END:
- ready_o=1 and result_o is held.
- Stay in END while start_i=1.
- When start_i=0, go to FREE next edge; ready_o and result_o clear to 0.

Abort:
- In BY_ZERO, ON or END, annul_i=1 or start_i=0 returns to FREE on the next edge.
- On abort, ready_o=0, result_o=0 and the partial state is discarded.
- annul_i has priority over start_i in every state.

busy_o is combinational from the state register.

## Timing
Reset (rst=0, asynchronous): state=FREE, cnt=0, result_o=0, ready_o=0, busy_o=0, and all internal registers are 0. Reset mid-operation abandons the divide with no residual state.

Latency from the accepting edge E0:
- Normal divide: ON from E0, iterations on E1..E32, END entered at E33, ready_o high after E33 (33 cycles).
- Divide by zero: BY_ZERO after E0, END after E1 (ready_o high after E1).

Handshake:
- ready_o stays high for every cycle start_i remains high in END.
- A new request is accepted only in FREE, so there is at least one FREE cycle between back-to-back divides.

Simultaneous events:
- start_i=1 with annul_i=1 in FREE: not accepted.
- annul_i in the cycle ready_o first rises: result discarded, FREE next edge.

## Structure
- Shared defines/package: state encoding (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/DivResultNotReady, DivStart/DivStop, and the DIV/DIVU aluop codes alongside the existing EX op codes. RegBus and ZeroWord are reused.
- One sub-module is natural: div_step, a combinational single restoring iteration with inputs {rem, dividend, divisor} and outputs {rem', dividend', qbit}.
- The FSM, counter and sign fix-up stay in ex_div_seq.

## Test plan
- Unsigned 100/7, start held: ready_o rises 33 cycles after acceptance; result_o = {32'd2, 32'd14}; busy_o high in between.
- Signed −7/2 (0xFFFFFFF9, 0x00000002): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also signed 7/−2: quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero 5/0: ready_o high after 2 edges; result_o = 0.
- annul_i pulsed at iteration 10: FREE next edge with ready_o=0 and result_o=0. A following DIVU 0xFFFFFFFF/1 gives quotient 0xFFFFFFFF, remainder 0.
- Signed 0x80000000/0xFFFFFFFF: quotient 0x80000000, remainder 0. Lowering start_i in END gives FREE next edge with outputs cleared.
- rst driven low mid-ON between clock edges: outputs go 0 immediately. After release, a fresh 9/3 divide completes correctly with quotient 3, remainder 0.

Source files
------------

// File: rtl/ex_div_seq_pkg.sv
// Shared definitions for the EX-stage divide sequencer: FSM encoding,
// handshake levels and the EX aluop codes that select DIV/DIVU.
package ex_div_seq_pkg;

  localparam int RegBus = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] ExeNopOp   = 8'b0000_0000;
  localparam logic [7:0] ExeAndOp   = 8'b0010_0100;
  localparam logic [7:0] ExeOrOp    = 8'b0010_0101;
  localparam logic [7:0] ExeMultOp  = 8'b0001_1000;
  localparam logic [7:0] ExeMultuOp = 8'b0001_1001;
  localparam logic [7:0] ExeDivOp   = 8'b0001_1010;
  localparam logic [7:0] ExeDivuOp  = 8'b0001_1011;

endpackage

// File: rtl/ex_div_seq_div_step.sv
// One combinational restoring-divide iteration: shift {rem, dividend} left,
// trial-subtract the divisor and keep the difference when it is non-negative.
module ex_div_seq_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] dvd_i,
  input  logic [DATA_W-1:0] dsr_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] dvd_o,
  output logic              qbit_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // The shifted remainder is below 2*divisor, so DATA_W+1 bits hold the sign.
  always_comb begin
    shifted = {rem_i, dvd_i[DATA_W-1]};
    trial   = shifted - {1'b0, dsr_i};
    qbit_o  = ~trial[DATA_W];
    rem_o   = qbit_o ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    dvd_o   = {dvd_i[DATA_W-2:0], 1'b0};
  end

endmodule

// File: rtl/ex_div_seq.sv
// Multi-cycle signed/unsigned radix-2 restoring divider for the EX stage.
// Result is {remainder, quotient}, presented with a ready/hold handshake.
module ex_div_seq
  import ex_div_seq_pkg::*;
#(
  parameter int DATA_W = RegBus
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dsr_q, dsr_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   rem_nx, dvd_nx;
  logic                qbit;
  logic                op1_neg, op2_neg, abort;

  ex_div_seq_div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i  (rem_q),
    .dvd_i  (dvd_q),
    .dsr_i  (dsr_q),
    .rem_o  (rem_nx),
    .dvd_o  (dvd_nx),
    .qbit_o (qbit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    op1_neg   = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg   = signed_div_i & opdata2_i[DATA_W-1];
    abort     = annul_i | (start_i == DivStop);

    if (state_q != DivFree && abort) begin
      // Leaving a divide early or after hand-off: drop every trace of it.
      state_d   = DivFree;
      cnt_d     = '0;
      rem_d     = '0;
      dvd_d     = '0;
      dsr_d     = '0;
      neg_quo_d = 1'b0;
      neg_rem_d = 1'b0;
      result_d  = '0;
      ready_d   = DivResultNotReady;
    end else begin
      unique case (state_q)
        DivFree: begin
          if (start_i == DivStart && !annul_i) begin
            dvd_d     = op1_neg ? -opdata1_i : opdata1_i;
            dsr_d     = op2_neg ? -opdata2_i : opdata2_i;
            neg_quo_d = op1_neg ^ op2_neg;
            neg_rem_d = op1_neg;
            rem_d     = '0;
            cnt_d     = '0;
            state_d   = (opdata2_i == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          result_d = '0;
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end
        DivOn: begin
          if (cnt_q != CNT_W'(DATA_W)) begin
            rem_d = rem_nx;
            dvd_d = dvd_nx | {{(DATA_W-1){1'b0}}, qbit};
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            result_d = {neg_rem_q ? -rem_q : rem_q, neg_quo_q ? -dvd_q : dvd_q};
            ready_d  = DivResultReady;
            state_d  = DivEnd;
          end
        end
        DivEnd: begin
          state_d = DivEnd;
        end
        default: state_d = DivFree;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == DivByZero) || (state_q == DivOn);

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed bench for ex_div_seq: the driver pushes expected {rem, quo} and the
// cycle ready_o should rise; a monitor pops on each ready_o rising edge.
module tb_ex_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  typedef struct {
    string       nm;
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic ready_prev = 1'b0;

  ex_div_seq #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge of ready_o.
  always @(negedge clk) begin
    if (rst && ready_o && !ready_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: got result %h expected no ready", result_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.nm, "_result"}, result_o, e.res);
        chk({e.nm, "_latency"}, 64'(cyc), 64'(e.cyc));
      end
    end
    ready_prev = ready_o;
  end

  // mode 0: hold then drop start; 1: annul when ready rises; 2: async reset in END
  task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic [63:0] exp_res, input int lat,
                         input int mode);
    exp_t e;
    int   waited;
    @(negedge clk);
    opdata1_i = a;
    opdata2_i = b;
    signed_div_i = sg;
    start_i = 1'b1;
    annul_i = 1'b0;
    e.nm = nm;
    e.res = exp_res;
    e.cyc = cyc + 1 + lat;
    sb_q.push_back(e);
    @(negedge clk);
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    signed_div_i = ~sg;
    chk({nm, "_busy"}, 64'(busy_o), 64'(1));
    waited = 0;
    while (!ready_o && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_o) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no ready after %0d cycles expected ready", nm, waited);
    end
    if (mode == 0) begin
      @(negedge clk);
      chk({nm, "_hold_ready"}, 64'(ready_o), 64'(1));
      chk({nm, "_hold_result"}, result_o, exp_res);
      start_i = 1'b0;
      @(negedge clk);
      chk({nm, "_clr_ready"}, 64'(ready_o), 64'(0));
      chk({nm, "_clr_result"}, result_o, 64'(0));
    end else if (mode == 1) begin
      annul_i = 1'b1;
      @(negedge clk);
      chk({nm, "_annul_ready"}, 64'(ready_o), 64'(0));
      chk({nm, "_annul_result"}, result_o, 64'(0));
      start_i = 1'b0;
      annul_i = 1'b0;
    end else begin
      #2 rst = 1'b0;
      #1;
      chk({nm, "_rst_ready"}, 64'(ready_o), 64'(0));
      chk({nm, "_rst_result"}, result_o, 64'(0));
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end
    @(negedge clk);
    chk({nm, "_idle_busy"}, 64'(busy_o), 64'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready_o), 64'(0));
    chk("reset_result", result_o, 64'(0));
    chk("reset_busy", 64'(busy_o), 64'(0));
    rst = 1'b1;

    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 0);
    run_div("div_m7_2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
    run_div("div_7_m2", 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0);
    run_div("divu_7_m2", 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, {32'h0000_0007, 32'h0000_0000}, 33, 0);
    run_div("div_5_0", 32'd5, 32'd0, 1'b1, 64'd0, 1, 0);

    // Annul at iteration 10, held together with start so FREE must refuse it.
    @(negedge clk);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    signed_div_i = 1'b0;
    start_i = 1'b1;
    repeat (10) @(negedge clk);
    chk("annul_pre_busy", 64'(busy_o), 64'(1));
    annul_i = 1'b1;
    @(negedge clk);
    chk("annul_ready", 64'(ready_o), 64'(0));
    chk("annul_result", result_o, 64'(0));
    chk("annul_busy", 64'(busy_o), 64'(0));
    @(negedge clk);
    chk("annul_start_refused", 64'(busy_o), 64'(0));
    start_i = 1'b0;
    annul_i = 1'b0;

    run_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 33, 0);
    run_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 33, 0);
    run_div("divu_20_6_annul", 32'd20, 32'd6, 1'b0, {32'd2, 32'd3}, 33, 1);

    // Asynchronous reset between edges while ON.
    @(negedge clk);
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    signed_div_i = 1'b0;
    start_i = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_on_pre_busy", 64'(busy_o), 64'(1));
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_on_busy", 64'(busy_o), 64'(0));
    chk("rst_on_ready", 64'(ready_o), 64'(0));
    chk("rst_on_result", result_o, 64'(0));
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    run_div("divu_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 0);
    run_div("div_m9_m4_rst", 32'hFFFF_FFF7, 32'hFFFF_FFFC, 1'b1, {32'hFFFF_FFFF, 32'd2}, 33, 2);

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
